edge_event_arbiter: RTL and testbench

Multi-channel edge-event controller for the PWM ramp IP. It watches `NumCh` synchronous level inputs and detects rising and/or falling edges per channel under per-channel configuration. Detected edges are held as pending events and serialized, round-robin, onto a single valid/ready event port. The event port is consumed by the ramp sequencer and the interrupt logic.

---
 rtl/edge_evt_pkg.sv | 4 +
 rtl/edge_evt_rr_arb.sv | 38 +++
 rtl/edge_event_arbiter.sv | 107 ++++++++++
 tb/tb_edge_event_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// edge_evt_pkg: shared types for the edge_event_arbiter block.
package edge_evt_pkg;
  typedef enum logic {IDLE, HOLD} edge_evt_state_e;
endpackage

// File: rtl/edge_evt_rr_arb.sv
// edge_evt_rr_arb: round-robin grant over a request vector; the pointer advances only on gnt_en_i.
// Ports: clk_i/rst_ni clock and async active-low reset, req_i requests, gnt_en_i grant strobe,
//        gnt_oh_o one-hot grant, gnt_idx_o grant index.
module edge_evt_rr_arb #(
  parameter int NumCh = 4,
  localparam int ChW = $clog2(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] req_i,
  input  logic             gnt_en_i,
  output logic [NumCh-1:0] gnt_oh_o,
  output logic [ChW-1:0]   gnt_idx_o
);
  logic [ChW-1:0] last_q, last_d;
  logic found;
  int c;
  always_comb begin
    found = 1'b0;
    gnt_idx_o = '0;
    c = 0;
    for (int i = 1; i <= NumCh; i++) begin
      c = int'(last_q) + i;
      c = c >= NumCh ? c - NumCh : c;
      if (!found && req_i[ChW'(c)]) begin
        found = 1'b1;
        gnt_idx_o = ChW'(c);
      end
    end
    gnt_oh_o = found ? NumCh'(1) << gnt_idx_o : '0;
    last_d = (gnt_en_i && found) ? gnt_idx_o : last_q;
  end
  // Pointer resets to the last channel so the first search begins at channel 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= ChW'(NumCh - 1);
    else last_q <= last_d;
  end
endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel edge capture with pending/overflow tracking, serialized round-robin onto a valid/ready port.
// Ports: sig_i levels; cfg_en_i/cfg_rise_i/cfg_fall_i capture selection; ovf_clr_i sticky-overflow clear;
//        evt_valid_o/evt_ready_i/evt_ch_o/evt_rise_o event port; pend_o/ovf_o status vectors.
// Optional: define EDGE_EVT_TIMESTAMP_EN to add a free-running counter and the evt_ts_o port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NumCh = 4,
  parameter int TsW = 16,
  localparam int ChW = $clog2(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NumCh-1:0] sig_i,
  input  logic [NumCh-1:0] cfg_en_i,
  input  logic [NumCh-1:0] cfg_rise_i,
  input  logic [NumCh-1:0] cfg_fall_i,
  input  logic [NumCh-1:0] ovf_clr_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ChW-1:0]   evt_ch_o,
  output logic             evt_rise_o,
`ifdef EDGE_EVT_TIMESTAMP_EN
  output logic [TsW-1:0]   evt_ts_o,
`endif
  output logic [NumCh-1:0] pend_o,
  output logic [NumCh-1:0] ovf_o
);
  if (NumCh < 2 || NumCh > 32 || TsW < 1) begin : g_bad_param
    $error("edge_event_arbiter: NumCh must be 2..32 and TsW >= 1");
  end
  edge_evt_state_e state_q, state_d;
  logic [NumCh-1:0] sig_q, pend_q, pend_d, pend_rise_q, pend_rise_d, ovf_q, ovf_d;
  logic [NumCh-1:0] rise, fall, hit, busy, load, gnt_oh;
  logic [ChW-1:0] gnt_idx, evt_ch_q, evt_ch_d;
  logic evt_rise_q, evt_rise_d, gnt_en;
  edge_evt_rr_arb #(.NumCh(NumCh)) u_arb (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(pend_q),
    .gnt_en_i(gnt_en),
    .gnt_oh_o(gnt_oh),
    .gnt_idx_o(gnt_idx)
  );
  // busy: pending and not being handed to the output register this cycle, so a new edge is an overflow.
  always_comb begin
    rise = sig_i & ~sig_q;
    fall = ~sig_i & sig_q;
    hit = cfg_en_i & ((rise & cfg_rise_i) | (fall & cfg_fall_i));
    gnt_en = (|pend_q) && (state_q == IDLE || evt_ready_i);
    busy = pend_q & ~(gnt_en ? gnt_oh : '0);
    load = hit & ~busy;
    pend_d = cfg_en_i & (busy | hit);
    pend_rise_d = (load & rise) | (~load & pend_rise_q);
    ovf_d = (hit & busy) | (ovf_q & ~ovf_clr_i);
    state_d = gnt_en ? HOLD : (evt_ready_i ? IDLE : state_q);
    evt_ch_d = gnt_en ? gnt_idx : evt_ch_q;
    evt_rise_d = gnt_en ? |(pend_rise_q & gnt_oh) : evt_rise_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sig_q <= '0;
      pend_q <= '0;
      pend_rise_q <= '0;
      ovf_q <= '0;
      evt_ch_q <= '0;
      evt_rise_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q <= sig_i;
      pend_q <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovf_q <= ovf_d;
      evt_ch_q <= evt_ch_d;
      evt_rise_q <= evt_rise_d;
    end
  end
  assign evt_valid_o = state_q == HOLD;
  assign evt_ch_o = evt_ch_q;
  assign evt_rise_o = evt_rise_q;
  assign pend_o = pend_q;
  assign ovf_o = ovf_q;
`ifdef EDGE_EVT_TIMESTAMP_EN
  logic [TsW-1:0] cnt_q, cnt_d, evt_ts_q, evt_ts_d;
  logic [TsW-1:0] ts_q [NumCh];
  logic [TsW-1:0] ts_d [NumCh];
  // Timestamps are written only on a fresh load, so an overflowing edge leaves the stored one intact.
  always_comb begin
    cnt_d = cnt_q + TsW'(1);
    for (int i = 0; i < NumCh; i++) ts_d[i] = load[i] ? cnt_q : ts_q[i];
    evt_ts_d = gnt_en ? ts_q[gnt_idx] : evt_ts_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      evt_ts_q <= '0;
      for (int i = 0; i < NumCh; i++) ts_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      evt_ts_q <= evt_ts_d;
      for (int i = 0; i < NumCh; i++) ts_q[i] <= ts_d[i];
    end
  end
  assign evt_ts_o = evt_ts_q;
`endif
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed literal checks plus randomized traffic compared every cycle to a behavioural model.
module tb_edge_event_arbiter;
  localparam int N = 4;
  localparam int TW = 4;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] sig_i = '0, cfg_en_i = '0, cfg_rise_i = '0, cfg_fall_i = '0, ovf_clr_i = '0;
  logic evt_ready_i = 1'b0;
  logic evt_valid_o, evt_rise_o;
  logic [1:0] evt_ch_o;
  logic [N-1:0] pend_o, ovf_o;
`ifdef EDGE_EVT_TIMESTAMP_EN
  logic [TW-1:0] evt_ts_o;
`endif
  edge_event_arbiter #(.NumCh(N), .TsW(TW)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .sig_i(sig_i),
    .cfg_en_i(cfg_en_i),
    .cfg_rise_i(cfg_rise_i),
    .cfg_fall_i(cfg_fall_i),
    .ovf_clr_i(ovf_clr_i),
    .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i),
    .evt_ch_o(evt_ch_o),
    .evt_rise_o(evt_rise_o),
`ifdef EDGE_EVT_TIMESTAMP_EN
    .evt_ts_o(evt_ts_o),
`endif
    .pend_o(pend_o),
    .ovf_o(ovf_o)
  );
  always #5 clk_i = ~clk_i;
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  // Behavioural model: a set of pending channels, a one-entry output slot, and a rotating search start.
  logic [N-1:0] m_sig, m_pend, m_prise, m_ovf;
  logic [TW-1:0] m_cnt, m_ots;
  logic [TW-1:0] m_ts [N];
  logic m_valid, m_rise;
  int m_ch, m_last, taken, cand;
  bit m_r, m_f, m_hit, m_busy;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_sig = '0; m_pend = '0; m_prise = '0; m_ovf = '0; m_cnt = '0; m_ots = '0;
      m_valid = 1'b0; m_rise = 1'b0; m_ch = 0; m_last = N - 1;
      for (int c = 0; c < N; c++) m_ts[c] = '0;
    end else begin
      taken = -1;
      if (m_pend != '0 && (!m_valid || evt_ready_i)) begin
        for (int k = 1; k <= N; k++) begin
          cand = (m_last + k) % N;
          if (taken < 0 && m_pend[cand]) taken = cand;
        end
        m_valid = 1'b1; m_ch = taken; m_rise = m_prise[taken]; m_ots = m_ts[taken]; m_last = taken;
      end else if (m_valid && evt_ready_i) m_valid = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_r = sig_i[c] && !m_sig[c];
        m_f = !sig_i[c] && m_sig[c];
        m_hit = cfg_en_i[c] && ((m_r && cfg_rise_i[c]) || (m_f && cfg_fall_i[c]));
        m_busy = m_pend[c] && c != taken;
        if (!cfg_en_i[c]) m_pend[c] = 1'b0;
        else if (m_hit && !m_busy) begin
          m_pend[c] = 1'b1; m_prise[c] = m_r; m_ts[c] = m_cnt;
        end else if (!m_busy) m_pend[c] = 1'b0;
        if (m_hit && m_busy) m_ovf[c] = 1'b1;
        else if (ovf_clr_i[c]) m_ovf[c] = 1'b0;
      end
      m_sig = sig_i;
      m_cnt = m_cnt + TW'(1);
    end
  end
  always @(negedge clk_i) begin
    chk("m_valid", 32'(evt_valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("m_ch", 32'(evt_ch_o), m_ch);
      chk("m_rise", 32'(evt_rise_o), 32'(m_rise));
`ifdef EDGE_EVT_TIMESTAMP_EN
      chk("m_ts", 32'(evt_ts_o), 32'(m_ots));
`endif
    end
    chk("m_pend", 32'(pend_o), 32'(m_pend));
    chk("m_ovf", 32'(ovf_o), 32'(m_ovf));
  end
  initial begin
    cyc(2);
    chk("rst_valid", 32'(evt_valid_o), 0);
    chk("rst_ch", 32'(evt_ch_o), 0);
    chk("rst_rise", 32'(evt_rise_o), 0);
    chk("rst_pend", 32'(pend_o), 0);
    chk("rst_ovf", 32'(ovf_o), 0);
    rst_ni = 1'b1;
    // single rise on ch0, ready high
    cfg_en_i = 4'b0001; cfg_rise_i = 4'b0001; evt_ready_i = 1'b1; sig_i = 4'b0001;
    cyc(); chk("s1_pend", 32'(pend_o), 32'b0001); chk("s1_novalid", 32'(evt_valid_o), 0);
    cyc(); chk("s1_valid", 32'(evt_valid_o), 1); chk("s1_ch", 32'(evt_ch_o), 0); chk("s1_rise", 32'(evt_rise_o), 1);
    cyc(); chk("s1_drop", 32'(evt_valid_o), 0);
    // ch1 and ch3 together; ch1 falls during its own grant and waits behind ch3
    cfg_en_i = 4'b1111; cfg_rise_i = 4'b1111; cfg_fall_i = 4'b0010; sig_i = 4'b1011;
    cyc(); chk("s2_pend", 32'(pend_o), 32'b1010);
    sig_i = 4'b1001;
    cyc(); chk("s2_ch1", 32'(evt_ch_o), 1); chk("s2_pend_reload", 32'(pend_o), 32'b1010); chk("s2_no_ovf", 32'(ovf_o), 0);
    cyc(); chk("s2_ch3", 32'(evt_ch_o), 3); chk("s2_ch3_rise", 32'(evt_rise_o), 1);
    cyc(); chk("s2_ch1b", 32'(evt_ch_o), 1); chk("s2_ch1b_fall", 32'(evt_rise_o), 0);
    cyc(); chk("s2_idle", 32'(evt_valid_o), 0);
    // stalled ch2 with overflow, then clear
    evt_ready_i = 1'b0; cfg_fall_i = 4'b0100; sig_i = 4'b1101;
    cyc(); chk("s3_pend", 32'(pend_o), 32'b0100);
    sig_i = 4'b1001;
    cyc();
    sig_i = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("s3_stall_valid", 32'(evt_valid_o), 1); chk("s3_stall_ch", 32'(evt_ch_o), 2);
      chk("s3_stall_rise", 32'(evt_rise_o), 1); chk("s3_ovf", 32'(ovf_o), 32'b0100);
    end
    evt_ready_i = 1'b1;
    cyc(); chk("s3_next_ch", 32'(evt_ch_o), 2); chk("s3_next_fall", 32'(evt_rise_o), 0); chk("s3_pend0", 32'(pend_o), 0);
    cyc(); chk("s3_idle", 32'(evt_valid_o), 0); chk("s3_ovf_sticky", 32'(ovf_o), 32'b0100);
    ovf_clr_i = 4'b0100;
    cyc(); chk("s3_ovf_clr", 32'(ovf_o), 0);
    ovf_clr_i = '0;
    // fall-only on ch0
    cfg_en_i = '0; sig_i = 4'b1100;
    cyc();
    cfg_en_i = 4'b0001; cfg_rise_i = '0; cfg_fall_i = 4'b0001; sig_i = 4'b1101;
    cyc(); chk("s4_no_rise", 32'(pend_o), 0);
    sig_i = 4'b1100;
    cyc(); chk("s4_pend", 32'(pend_o), 32'b0001);
    cyc(); chk("s4_valid", 32'(evt_valid_o), 1); chk("s4_fall", 32'(evt_rise_o), 0);
    cyc(); chk("s4_idle", 32'(evt_valid_o), 0);
    // enable dropped while ch1 waits behind a stalled ch0
    cfg_en_i = 4'b0011; cfg_rise_i = 4'b0011; cfg_fall_i = '0; evt_ready_i = 1'b0; sig_i = 4'b1101;
    cyc();
    cyc(); chk("s5_hold_ch0", 32'(evt_ch_o), 0);
    sig_i = 4'b1111;
    cyc(); chk("s5_pend1", 32'(pend_o), 32'b0010);
    cfg_en_i = 4'b0001;
    cyc(); chk("s5_pend_clr", 32'(pend_o), 0); chk("s5_still_valid", 32'(evt_valid_o), 1);
    evt_ready_i = 1'b1;
    cyc(); chk("s5_no_evt", 32'(evt_valid_o), 0);
    cyc(); chk("s5_no_evt2", 32'(evt_valid_o), 0);
    // reset in HOLD, then timestamp after 20 idle cycles
    evt_ready_i = 1'b0; cfg_rise_i = '0; cfg_fall_i = 4'b0001; sig_i = 4'b1110;
    cyc(2); chk("s6_hold", 32'(evt_valid_o), 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(evt_valid_o), 0); chk("s6_rst_pend", 32'(pend_o), 0);
    chk("s6_rst_ch", 32'(evt_ch_o), 0); chk("s6_rst_ovf", 32'(ovf_o), 0);
`ifdef EDGE_EVT_TIMESTAMP_EN
    chk("s6_rst_ts", 32'(evt_ts_o), 0);
`endif
    cyc();
    sig_i = '0; cfg_rise_i = 4'b0001; cfg_fall_i = '0; evt_ready_i = 1'b1; rst_ni = 1'b1;
    cyc(20);
    sig_i = 4'b0001;
    cyc(2); chk("s6_valid", 32'(evt_valid_o), 1);
`ifdef EDGE_EVT_TIMESTAMP_EN
    chk("s6_ts", 32'(evt_ts_o), 4);
`endif
    cyc();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        cfg_en_i = N'($urandom | $urandom);
        cfg_rise_i = N'($urandom);
        cfg_fall_i = N'($urandom);
      end
      sig_i = sig_i ^ N'($urandom & $urandom);
      evt_ready_i = $urandom_range(0, 3) != 0;
      ovf_clr_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if (i % 997 == 500) begin
        #2 rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
      end else cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
